// File: rtl/nios2_cordic_cpu_mul_seq.sv
// Multicycle 32x32 -> 64 multiply sequencer driving one shared pipelined 16x16 multiplier cell.
// Optional macro NIOS2_CORDIC_MUL_SEQ_EARLY_LOW_EN skips the HH partial product for op=00.
module nios2_cordic_cpu_mul_seq #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIX   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  // Tag pipe: shift code 0/1/2 selects a left shift of 0/16/32 bits
  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic [1:0]             sh_q [MUL_LATENCY];
  logic [1:0]             sh_d [MUL_LATENCY];

  logic        issue;
  logic        last_issue;
  logic        pending;
  logic [63:0] fixed;
  logic [63:0] corr_a;
  logic [63:0] corr_b;

  assign issue  = (state_q == S_ISSUE);
  assign mul_en = issue;
  assign mul_a  = issue ? (cnt_q[0] ? a_q[31:16] : a_q[15:0]) : 16'h0000;
  assign mul_b  = issue ? (cnt_q[1] ? b_q[31:16] : b_q[15:0]) : 16'h0000;

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;

`ifdef NIOS2_CORDIC_MUL_SEQ_EARLY_LOW_EN
  assign last_issue = (cnt_q == 2'd3) || ((op_q == 2'b00) && (cnt_q == 2'd2));
`else
  assign last_issue = (cnt_q == 2'd3);
`endif

  // Signed correction: two's complement operand value = unsigned value - sign * 2^32
  assign corr_a = (op_q[1] && a_q[31]) ? {b_q, 32'h0} : 64'h0;
  assign corr_b = ((op_q == 2'b11) && b_q[31]) ? {a_q, 32'h0} : 64'h0;
  assign fixed  = acc_q - corr_a - corr_b;

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < MUL_LATENCY - 1; i++) begin
      pending = pending | vld_q[i];
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    sh_d[0]  = (cnt_q == 2'd0) ? 2'd0 : ((cnt_q == 2'd3) ? 2'd2 : 2'd1);
    for (int i = 1; i < MUL_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      sh_d[i]  = sh_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;

    if (vld_q[MUL_LATENCY-1]) begin
      acc_d = acc_q + ({32'h0, mul_p} << {sh_q[MUL_LATENCY-1], 4'b0000});
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = src_a;
          b_d     = src_b;
          op_d    = op;
          acc_d   = 64'h0;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        lo_d    = fixed[31:0];
        hi_d    = (op_q == 2'b00) ? 32'h0 : fixed[63:32];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      op_q    <= 2'b00;
      acc_q   <= 64'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
      vld_q   <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        sh_q[i] <= 2'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      vld_q   <= vld_d;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

endmodule

// File: tb/tb_nios2_cordic_cpu_mul_seq.sv
// Self-checking bench for nios2_cordic_cpu_mul_seq: two instances (MUL_LATENCY 1 and 3) share stimulus,
// each with its own behavioural 16x16 multiplier cell and its own expected-result queue.
module tb_nios2_cordic_cpu_mul_seq;

  localparam int NDUT   = 2;
  localparam int MAXE   = 12;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;

  logic [NDUT-1:0]        busy_w;
  logic [NDUT-1:0]        done_w;
  logic [NDUT-1:0]        men_w;
  logic [NDUT-1:0][31:0]  lo_w;
  logic [NDUT-1:0][31:0]  hi_w;
  logic [NDUT-1:0][31:0]  mp_w;
  logic [NDUT-1:0][15:0]  ma_w;
  logic [NDUT-1:0][15:0]  mb_w;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
    int          nen;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] pipe [LAT];

    nios2_cordic_cpu_mul_seq #(.MUL_LATENCY(LAT)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .src_a     (src_a),
      .src_b     (src_b),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .result_lo (lo_w[g]),
      .result_hi (hi_w[g]),
      .mul_a     (ma_w[g]),
      .mul_b     (mb_w[g]),
      .mul_en    (men_w[g]),
      .mul_p     (mp_w[g])
    );

    // Garbage on idle slots exposes any accumulation of an unissued product
    always @(posedge clk) begin
      pipe[0] <= men_w[g] ? ({16'h0, ma_w[g]} * {16'h0, mb_w[g]}) : 32'hDEAD_BEEF;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mp_w[g] = pipe[LAT-1];
  end

  function automatic logic [63:0] ref_product(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = o[1] ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (o == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    if (o == 2'b00) p[63:32] = 32'h0;
    return p;
  endfunction

  function automatic exp_t ref_entry(input int g, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    p     = ref_product(o, a, b);
    e.lo  = p[31:0];
    e.hi  = p[63:32];
    e.lat = ((g == 0) ? 1 : 3) + 5;
    e.nen = 4;
`ifdef NIOS2_CORDIC_MUL_SEQ_EARLY_LOW_EN
    if (o == 2'b00) begin
      e.lat = e.lat - 1;
      e.nen = 3;
    end
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    sb0.push_back(ref_entry(0, o, a, b));
    sb1.push_back(ref_entry(1, o, a, b));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    src_a   = 32'h0;
    src_b   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if ({busy_w[g], done_w[g], men_w[g], lo_w[g], hi_w[g], ma_w[g], mb_w[g]} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d: busy=%b done=%b en=%b lo=%h hi=%h a=%h b=%h, all required 0",
                 g, busy_w[g], done_w[g], men_w[g], lo_w[g], hi_w[g], ma_w[g], mb_w[g]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [1:0]  t_op [10];
    logic [31:0] t_a  [10];
    logic [31:0] t_b  [10];
    int          t_inj[10];
    t_op[0] = 2'b01; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'hFFFF_FFFF; t_inj[0] = 0;
    t_op[1] = 2'b11; t_a[1] = 32'hFFFF_FFFE; t_b[1] = 32'h0000_0003; t_inj[1] = 0;
    t_op[2] = 2'b10; t_a[2] = 32'h8000_0000; t_b[2] = 32'h0000_0002; t_inj[2] = 0;
    t_op[3] = 2'b01; t_a[3] = 32'h8000_0000; t_b[3] = 32'h0000_0002; t_inj[3] = 0;
    t_op[4] = 2'b00; t_a[4] = 32'h0001_0003; t_b[4] = 32'h0002_0005; t_inj[4] = 0;
    t_op[5] = 2'b01; t_a[5] = 32'h0000_0005; t_b[5] = 32'h0000_0007; t_inj[5] = 2;
    for (int i = 6; i < 10; i++) begin
      t_op[i] = 2'(i - 6); t_a[i] = $urandom; t_b[i] = $urandom; t_inj[i] = 0;
    end

    for (int c = 0; c < 10; c++) begin
      int   ndone [NDUT];
      int   nen   [NDUT];
      int   done_e[NDUT];
      int   busy_bad[NDUT];
      int   idle_bad[NDUT];
      exp_t ex    [NDUT];

      applyStimulus(t_op[c], t_a[c], t_b[c]);
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      checks++;
      if (busy_w !== '1) begin
        errors++;
        $display("[TB] FAIL busy_after_accept case%0d: busy=%b, required 11", c, busy_w);
      end
      for (int g = 0; g < NDUT; g++) begin
        ndone[g] = 0; done_e[g] = -1; busy_bad[g] = 0; idle_bad[g] = 0; ex[g] = '0;
        nen[g] = men_w[g] ? 1 : 0;
        if (!men_w[g] && (ma_w[g] != 16'h0 || mb_w[g] != 16'h0)) idle_bad[g]++;
      end

      for (int e = 1; e <= MAXE; e++) begin
        if (t_inj[c] != 0 && e == t_inj[c]) begin
          start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
          if (done_w[g]) begin
            ndone[g]++;
            if (ndone[g] == 1) begin
              done_e[g] = e;
              checks++;
              if ((g == 0 && sb0.size() == 0) || (g == 1 && sb1.size() == 0)) begin
                errors++;
                $display("[TB] FAIL scoreboard_empty case%0d dut%0d: done with no pending request", c, g);
              end else begin
                if (g == 0) ex[g] = sb0.pop_front();
                else        ex[g] = sb1.pop_front();
                if (lo_w[g] !== ex[g].lo || hi_w[g] !== ex[g].hi) begin
                  errors++;
                  $display("[TB] FAIL checkOutput result case%0d dut%0d: got hi=%h lo=%h, expected hi=%h lo=%h",
                           c, g, hi_w[g], lo_w[g], ex[g].hi, ex[g].lo);
                end
              end
              checks++;
              if (busy_w[g] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_at_done case%0d dut%0d: busy=%b, required 0", c, g, busy_w[g]);
              end
            end
          end else if (done_e[g] < 0 && busy_w[g] !== 1'b1) begin
            busy_bad[g]++;
          end
          if (men_w[g]) nen[g]++;
          else if (ma_w[g] != 16'h0 || mb_w[g] != 16'h0) idle_bad[g]++;
        end
      end

      for (int g = 0; g < NDUT; g++) begin
        if (ndone[g] == 0) begin
          if (g == 0 && sb0.size() != 0) ex[g] = sb0.pop_front();
          if (g == 1 && sb1.size() != 0) ex[g] = sb1.pop_front();
          ex[g] = ref_entry(g, t_op[c], t_a[c], t_b[c]);
        end
        checks++;
        if (ndone[g] != 1) begin
          errors++;
          $display("[TB] FAIL done_count case%0d dut%0d: got %0d pulses within %0d edges, expected 1", c, g, ndone[g], MAXE);
        end
        checks++;
        if (done_e[g] != ex[g].lat) begin
          errors++;
          $display("[TB] FAIL done_edge case%0d dut%0d: done at E%0d, expected E%0d", c, g, done_e[g], ex[g].lat);
        end
        checks++;
        if (nen[g] != ex[g].nen) begin
          errors++;
          $display("[TB] FAIL mul_en_cycles case%0d dut%0d: got %0d, expected %0d", c, g, nen[g], ex[g].nen);
        end
        checks++;
        if (busy_bad[g] != 0 || idle_bad[g] != 0) begin
          errors++;
          $display("[TB] FAIL busy_and_idle_operands case%0d dut%0d: busy-low cycles=%0d nonzero idle operand cycles=%0d, expected 0 and 0",
                   c, g, busy_bad[g], idle_bad[g]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    int   done_e[NDUT];
    int   spurious;
    exp_t ex;
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if ({busy_w[g], done_w[g], men_w[g], lo_w[g], hi_w[g], ma_w[g], mb_w[g]} !== '0) begin
        errors++;
        $display("[TB] FAIL midop_reset_outputs dut%0d: busy=%b done=%b en=%b lo=%h hi=%h a=%h b=%h, all required 0",
                 g, busy_w[g], done_w[g], men_w[g], lo_w[g], hi_w[g], ma_w[g], mb_w[g]);
      end
    end
    spurious = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_w !== '0) spurious++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done_w !== '0 || busy_w !== '0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("[TB] FAIL abandoned_op_activity: %0d cycles with done or busy, expected 0", spurious);
    end

    applyStimulus(2'b01, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    done_e = '{-1, -1};
    for (int e = 1; e <= MAXE; e++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NDUT; g++) begin
        if (done_w[g] && done_e[g] < 0) begin
          done_e[g] = e;
          if (g == 0) ex = sb0.pop_front();
          else        ex = sb1.pop_front();
          checks++;
          if (lo_w[g] !== 32'h0000_0006 || hi_w[g] !== 32'h0 || lo_w[g] !== ex.lo) begin
            errors++;
            $display("[TB] FAIL post_reset_result dut%0d: got hi=%h lo=%h, expected hi=00000000 lo=00000006", g, hi_w[g], lo_w[g]);
          end
          checks++;
          if (e != ex.lat) begin
            errors++;
            $display("[TB] FAIL post_reset_done_edge dut%0d: done at E%0d, expected E%0d", g, e, ex.lat);
          end
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      if (done_e[g] < 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL post_reset_timeout dut%0d: no done within %0d edges, expected one", g, MAXE);
        if (g == 0 && sb0.size() != 0) ex = sb0.pop_front();
        if (g == 1 && sb1.size() != 0) ex = sb1.pop_front();
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_arith();
    test_reset_midop();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d and %0d entries left, expected 0 and 0", sb0.size(), sb1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
